// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with multi-cycle EX and fetch-discard contexts
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ld_use,
  input  logic              redirect,
  input  logic              fetch_wait,
  input  logic              mem_wait,
  input  logic              mc_req,
  input  logic [CNT_W-1:0]  mc_lat,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              mc_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULTI   = 2'd1,
    DISCARD = 2'd2
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  nextCnt;
  logic [PERF_W-1:0] perfCnt;

  // State and countdown register; mem_wait freezing is handled in the next-state logic
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Stall-cycle counter, wraps naturally at its width
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perfCnt <= '0;
    end else if (stall_f) begin
      perfCnt <= perfCnt + PERF_W'(1);
    end
  end

  // Priority resolution of hazard requests into stall/flush controls and next state
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    flush_w   = 1'b0;
    nextState = state;
    nextCnt   = cnt;
    if (!resetn) begin
      // Outputs must drop the same instant reset asserts, independent of the clock
      nextState = RUN;
      nextCnt   = '0;
    end else if (mem_wait) begin
      // Whole pipeline frozen; W gets a bubble so the stalled M result is not retired twice
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (state == MULTI && cnt != '0) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
      nextCnt = cnt - CNT_W'(1);
    end else if (state == MULTI) begin
      // Last E cycle of the op: E advances, only fetch may still be waiting
      if (fetch_wait) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
      end
      nextState = RUN;
    end else if (state == RUN && mc_req && mc_lat >= CNT_W'(2)) begin
      // First E cycle counts toward the latency, and the release cycle is the last one
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_e   = 1'b1;
      flush_m   = 1'b1;
      nextCnt   = mc_lat - CNT_W'(2);
      nextState = MULTI;
    end else if (redirect) begin
      flush_d   = 1'b1;
      flush_e   = 1'b1;
      nextState = fetch_wait ? DISCARD : RUN;
    end else if (state == DISCARD) begin
      // Hold fetch until the stale response arrives, then drop it as a bubble in D
      stall_f = 1'b1;
      flush_d = 1'b1;
      if (!fetch_wait) begin
        nextState = RUN;
      end
    end else if (ld_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (fetch_wait) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end
  end

  assign mc_busy      = resetn && (state == MULTI);
  assign stall_cycles = perfCnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural hazard model
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ld_use, redirect, fetch_wait, mem_wait, mc_req;
  logic [5:0]  mc_lat;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_m, flush_w;
  logic        mc_busy;
  logic [31:0] stall_cycles;
  logic [7:0]  outVecS;
  logic        busyS;
  logic [3:0]  perfS;
  logic [7:0]  outVec;

  localparam bit [7:0] sF = 8'h80, sD = 8'h40, sE = 8'h20, sM = 8'h10;
  localparam bit [7:0] fD = 8'h08, fE = 8'h04, fM = 8'h02, fW = 8'h01;

  int checks   = 0;
  int failures = 0;

  // Reference model: E cycles still owed to a multi-cycle op, and whether a stale fetch must be dropped
  int          mcLeft;
  bit          dropPending;
  bit [31:0]   perf;
  bit [7:0]    expVec;
  bit          expBusy;
  int          nxtLeft;
  bit          nxtDrop;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .resetn(resetn), .ld_use(ld_use), .redirect(redirect),
    .fetch_wait(fetch_wait), .mem_wait(mem_wait), .mc_req(mc_req), .mc_lat(mc_lat),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .mc_busy(mc_busy), .stall_cycles(stall_cycles)
  );

  pipe_ctrl #(.CNT_W(6), .PERF_W(4)) dutSmall (
    .clk(clk), .resetn(resetn), .ld_use(ld_use), .redirect(redirect),
    .fetch_wait(fetch_wait), .mem_wait(mem_wait), .mc_req(mc_req), .mc_lat(mc_lat),
    .stall_f(outVecS[7]), .stall_d(outVecS[6]), .stall_e(outVecS[5]), .stall_m(outVecS[4]),
    .flush_d(outVecS[3]), .flush_e(outVecS[2]), .flush_m(outVecS[1]), .flush_w(outVecS[0]),
    .mc_busy(busyS), .stall_cycles(perfS)
  );

  assign outVec = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};

  task automatic modelReset();
    mcLeft      = 0;
    dropPending = 1'b0;
    perf        = '0;
  endtask

  task automatic modelEval();
    expVec  = 8'h00;
    expBusy = (mcLeft > 0);
    nxtLeft = mcLeft;
    nxtDrop = dropPending;
    if (mem_wait) begin
      expVec = sF | sD | sE | sM | fW;
    end else if (mcLeft > 1) begin
      expVec  = sF | sD | sE | fM;
      nxtLeft = mcLeft - 1;
    end else if (mcLeft == 1) begin
      if (fetch_wait) expVec = sF | fD;
      nxtLeft = 0;
    end else if (!dropPending && mc_req && mc_lat >= 2) begin
      expVec  = sF | sD | sE | fM;
      nxtLeft = int'(mc_lat) - 1;
    end else if (redirect) begin
      expVec  = fD | fE;
      nxtDrop = fetch_wait;
    end else if (dropPending) begin
      expVec  = sF | fD;
      nxtDrop = fetch_wait;
    end else if (ld_use) begin
      expVec = sF | sD | fE;
    end else if (fetch_wait) begin
      expVec = sF | fD;
    end
  endtask

  // Input vector order: {ld_use, redirect, fetch_wait, mem_wait, mc_req}
  task automatic applyIn(input bit [4:0] v, input int lat);
    {ld_use, redirect, fetch_wait, mem_wait, mc_req} = v;
    mc_lat = 6'(lat);
    modelEval();
  endtask

  task automatic commitEdge();
    @(posedge clk);
    mcLeft      = nxtLeft;
    dropPending = nxtDrop;
    if (expVec[7]) perf = perf + 32'd1;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    applyIn(5'b11111, 5);
    @(negedge clk);
    checks++;
    if (outVec !== 8'h00 || mc_busy !== 1'b0 || stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold: got out=%b busy=%b perf=%0d, want out=00000000 busy=0 perf=0", outVec, mc_busy, stall_cycles);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    modelReset();
    for (int i = 0; i < 5; i++) begin
      applyIn(5'b00000, 0);
      @(negedge clk);
      checks++;
      if (outVec !== 8'h00 || mc_busy !== 1'b0 || stall_cycles !== 32'd0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: got out=%b busy=%b perf=%0d, want all 0", i, outVec, mc_busy, stall_cycles);
      end
      commitEdge();
    end
  endtask

  task automatic test_ld_use();
    bit [4:0] tbl [5] = '{5'b00000, 5'b10000, 5'b00000, 5'b11000, 5'b00000};
    bit [7:0] want [5] = '{8'h00, sF | sD | fE, 8'h00, fD | fE, 8'h00};
    for (int i = 0; i < 5; i++) begin
      applyIn(tbl[i], 0);
      @(negedge clk);
      checks++;
      if (outVec !== expVec || outVec !== want[i] || mc_busy !== expBusy || stall_cycles !== perf) begin
        failures++;
        $display("FAIL ld_use[%0d]: got out=%b busy=%b perf=%0d, want out=%b busy=%b perf=%0d", i, outVec, mc_busy, stall_cycles, want[i], expBusy, perf);
      end
      commitEdge();
    end
  endtask

  task automatic test_multi(input int memWaitCycle);
    int busyCount = 0;
    int stallCount = 0;
    int total = (memWaitCycle >= 0) ? 7 : 6;
    for (int i = 0; i < total; i++) begin
      bit inOp = (memWaitCycle >= 0) ? (i < 5) : (i < 4);
      applyIn({2'b00, 1'b0, (i == memWaitCycle), inOp}, 4);
      @(negedge clk);
      if (mc_busy) busyCount++;
      if (stall_e && !stall_m) stallCount++;
      checks++;
      if (outVec !== expVec || mc_busy !== expBusy || stall_cycles !== perf) begin
        failures++;
        $display("FAIL multi(mw=%0d)[%0d]: got out=%b busy=%b perf=%0d, want out=%b busy=%b perf=%0d", memWaitCycle, i, outVec, mc_busy, stall_cycles, expVec, expBusy, perf);
      end
      commitEdge();
    end
    checks++;
    if (busyCount !== ((memWaitCycle >= 0) ? 4 : 3) || stallCount !== 3) begin
      failures++;
      $display("FAIL multi_len(mw=%0d): got busy=%0d estall=%0d, want busy=%0d estall=3", memWaitCycle, busyCount, stallCount, (memWaitCycle >= 0) ? 4 : 3);
    end
  endtask

  task automatic test_discard();
    bit [4:0] tbl [6] = '{5'b01100, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00100};
    int flushCount = 0;
    for (int i = 0; i < 6; i++) begin
      applyIn(tbl[i], 0);
      @(negedge clk);
      if (i >= 1 && i <= 3 && flush_d && stall_f) flushCount++;
      checks++;
      if (outVec !== expVec || mc_busy !== expBusy || stall_cycles !== perf) begin
        failures++;
        $display("FAIL discard[%0d]: got out=%b busy=%b perf=%0d, want out=%b busy=%b perf=%0d", i, outVec, mc_busy, stall_cycles, expVec, expBusy, perf);
      end
      commitEdge();
    end
    checks++;
    if (flushCount !== 3) begin
      failures++;
      $display("FAIL discard_len: got %0d flush cycles, want 3", flushCount);
    end
  endtask

  task automatic test_mem_wait_priority();
    bit [4:0] tbl [3] = '{5'b11110, 5'b00000, 5'b10000};
    bit [7:0] want [3] = '{sF | sD | sE | sM | fW, 8'h00, sF | sD | fE};
    for (int i = 0; i < 3; i++) begin
      applyIn(tbl[i], 0);
      @(negedge clk);
      checks++;
      if (outVec !== expVec || outVec !== want[i] || mc_busy !== expBusy || stall_cycles !== perf) begin
        failures++;
        $display("FAIL mem_wait_prio[%0d]: got out=%b busy=%b perf=%0d, want out=%b busy=%b perf=%0d", i, outVec, mc_busy, stall_cycles, want[i], expBusy, perf);
      end
      commitEdge();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit [4:0] v;
      v[4] = ($urandom_range(0, 99) < 20);
      v[3] = ($urandom_range(0, 99) < 15);
      v[2] = ($urandom_range(0, 99) < 40);
      v[1] = ($urandom_range(0, 99) < 15);
      v[0] = ($urandom_range(0, 99) < 15);
      applyIn(v, $urandom_range(0, 7));
      @(negedge clk);
      checks++;
      if (outVec !== expVec || mc_busy !== expBusy || stall_cycles !== perf ||
          outVecS !== expVec || perfS !== perf[3:0]) begin
        failures++;
        $display("FAIL random[%0d]: got out=%b busy=%b perf=%0d small=%b/%0d, want out=%b busy=%b perf=%0d small=%0d", i, outVec, mc_busy, stall_cycles, outVecS, perfS, expVec, expBusy, perf, perf[3:0]);
      end
      commitEdge();
    end
  endtask

  task automatic test_async_reset();
    applyIn(5'b00001, 5);
    commitEdge();
    applyIn(5'b00101, 5);
    commitEdge();
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (outVec !== 8'h00 || mc_busy !== 1'b0 || stall_cycles !== 32'd0 || outVecS !== 8'h00 || busyS !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got out=%b busy=%b perf=%0d, want all 0", outVec, mc_busy, stall_cycles);
    end
    modelReset();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyIn((i == 1) ? 5'b10000 : 5'b00000, 0);
      @(negedge clk);
      checks++;
      if (outVec !== expVec || mc_busy !== expBusy || stall_cycles !== perf) begin
        failures++;
        $display("FAIL after_reset[%0d]: got out=%b busy=%b perf=%0d, want out=%b busy=%b perf=%0d", i, outVec, mc_busy, stall_cycles, expVec, expBusy, perf);
      end
      commitEdge();
    end
  endtask

  initial begin
    resetn = 1'b0;
    {ld_use, redirect, fetch_wait, mem_wait, mc_req} = '0;
    mc_lat = '0;
    modelReset();
    #2;
    test_reset();
    test_ld_use();
    test_multi(-1);
    test_multi(2);
    test_discard();
    test_mem_wait_priority();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
